// File: rtl/coef_dequant_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : coef_dequant_pipe                                                |
// | Purpose  : Elastic valid/ready coefficient dequantiser. Each coefficient is  |
// |            multiplied by an effective scale and a quant-table entry, then    |
// |            rounded (/8) and saturated to OUT_W bits.                         |
// |            Latency 3 cycles from accept, throughput 1 per cycle.            |
// | Ports    : i_clk, i_nrst (async active-low)                                  |
// |            input  handshake : i_valid / o_ready                              |
// |            input  data      : i_coef, i_scale, i_isDC, i_index,              |
// |                               i_linearIndex, i_tblSel, i_fullBlock,          |
// |                               i_blockNum, i_last                             |
// |            table write      : i_qWrt, i_qTbl, i_qAdr, i_qValue               |
// |            output handshake : o_valid / i_ready                              |
// |            output data      : o_index, o_blockNum, o_last, o_coef            |
// | Options  : DEQUANT_SAT_CNT_EN adds o_satCount / i_satClr (clamp counter).   |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module coef_dequant_pipe #(
    parameter int COEF_W     = 10,
    parameter int SCALE_W    = 6,
    parameter int QUANT_W    = 7,
    parameter int OUT_W      = 12,
    parameter int NUM_TABLES = 2,
    parameter int TBL_W      = $clog2(NUM_TABLES)   // derived, leave at default
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [COEF_W-1:0]      i_coef,
    input  logic [SCALE_W-1:0]     i_scale,
    input  logic                   i_isDC,
    input  logic [5:0]             i_index,
    input  logic [5:0]             i_linearIndex,
    input  logic [TBL_W-1:0]       i_tblSel,
    input  logic                   i_fullBlock,
    input  logic [2:0]             i_blockNum,
    input  logic                   i_last,
    input  logic                   i_qWrt,
    input  logic [TBL_W-1:0]       i_qTbl,
    input  logic [3:0]             i_qAdr,
    input  logic [4*QUANT_W-1:0]   i_qValue,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [5:0]             o_index,
    output logic [2:0]             o_blockNum,
    output logic                   o_last,
`ifdef DEQUANT_SAT_CNT_EN
    output logic [15:0]            o_satCount,
    input  logic                   i_satClr,
`endif
    output logic [OUT_W-1:0]       o_coef
);

    localparam int c_PROD_W = COEF_W + SCALE_W + QUANT_W + 2;
    localparam int c_ADR_W  = TBL_W + 4;
    localparam int c_WORDS  = NUM_TABLES * 16;
    localparam logic signed [c_PROD_W-1:0] c_RND     = c_PROD_W'(4);
    localparam logic signed [c_PROD_W-1:0] c_SAT_MAX = c_PROD_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [c_PROD_W-1:0] c_SAT_MIN = c_PROD_W'(-(2 ** (OUT_W - 1)));

    // ---------------- handshake ----------------
    logic w_s1Adv, w_s0Adv, w_inReady, w_accept;
    logic r_s0Valid, r_s1Valid, r_outValid;

    assign w_s1Adv   = !r_outValid || i_ready;
    assign w_s0Adv   = !r_s1Valid  || w_s1Adv;
    assign w_inReady = !r_s0Valid  || w_s0Adv;
    assign w_accept  = i_valid && w_inReady;
    assign o_ready   = w_inReady;

    // ---------------- quant table RAM (read-first, not reset) ----------------
    logic [4*QUANT_W-1:0] r_mem [c_WORDS];
    logic [4*QUANT_W-1:0] r_rdWord;
    logic [c_ADR_W-1:0]   w_rdAdr, w_wrAdr;

    // DC always uses entry 0 of the selected table, i.e. word 0.
    assign w_rdAdr = {i_tblSel, (i_isDC ? 4'd0 : i_linearIndex[5:2])};
    assign w_wrAdr = {i_qTbl, i_qAdr};

    // The read port runs every cycle; the word for an item is valid only in
    // the first cycle that item sits in S0, hence the hold register below.
    always_ff @(posedge i_clk) begin
        if (i_qWrt) begin
            r_mem[w_wrAdr] <= i_qValue;
        end
        r_rdWord <= r_mem[w_rdAdr];
    end

    // ---------------- S0: sideband + entry capture ----------------
    logic [COEF_W-1:0]  r_s0Coef;
    logic [SCALE_W-1:0] r_s0Scale;
    logic               r_s0IsDC, r_s0Full, r_s0Last, r_s0UseHold;
    logic [1:0]         r_s0Sel;
    logic [5:0]         r_s0Index;
    logic [2:0]         r_s0Blk;
    logic [QUANT_W-1:0] r_holdQ;
    logic [QUANT_W-1:0] w_ramEntry, w_s0Q, w_effQ;
    logic [SCALE_W-1:0] w_effS;

    always_comb begin
        w_ramEntry = r_rdWord[QUANT_W-1:0];
        case (r_s0Sel)
            2'd0:    w_ramEntry = r_rdWord[0*QUANT_W +: QUANT_W];
            2'd1:    w_ramEntry = r_rdWord[1*QUANT_W +: QUANT_W];
            2'd2:    w_ramEntry = r_rdWord[2*QUANT_W +: QUANT_W];
            default: w_ramEntry = r_rdWord[3*QUANT_W +: QUANT_W];
        endcase
    end

    assign w_s0Q = r_s0UseHold ? r_holdQ : w_ramEntry;

    always_comb begin
        w_effS = r_s0Scale;
        w_effQ = w_s0Q;
        if (r_s0Full) begin
            w_effS = SCALE_W'(16);
            w_effQ = QUANT_W'(1);
        end else if (r_s0IsDC) begin
            w_effS = SCALE_W'(8);
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_s0Valid   <= 1'b0;
            r_s0Coef    <= '0;
            r_s0Scale   <= '0;
            r_s0IsDC    <= 1'b0;
            r_s0Full    <= 1'b0;
            r_s0Sel     <= 2'd0;
            r_s0Index   <= 6'd0;
            r_s0Blk     <= 3'd0;
            r_s0Last    <= 1'b0;
            r_s0UseHold <= 1'b0;
            r_holdQ     <= '0;
        end else begin
            if (w_inReady) begin
                r_s0Valid <= i_valid;
                if (i_valid) begin
                    r_s0Coef  <= i_coef;
                    r_s0Scale <= i_scale;
                    r_s0IsDC  <= i_isDC;
                    r_s0Full  <= i_fullBlock;
                    r_s0Sel   <= i_isDC ? 2'd0 : i_linearIndex[1:0];
                    r_s0Index <= i_index;
                    r_s0Blk   <= i_blockNum;
                    r_s0Last  <= i_last;
                end
            end
            // Freeze the entry the first time an item stalls in S0, before the
            // free-running read port overwrites r_rdWord.
            if (w_accept) begin
                r_s0UseHold <= 1'b0;
            end else if (r_s0Valid && !w_s0Adv && !r_s0UseHold) begin
                r_s0UseHold <= 1'b1;
                r_holdQ     <= w_ramEntry;
            end
        end
    end

    // ---------------- S1: operands, product ----------------
    logic signed [COEF_W-1:0] r_s1Coef;
    logic [SCALE_W-1:0]       r_s1S;
    logic [QUANT_W-1:0]       r_s1Q;
    logic [5:0]               r_s1Index;
    logic [2:0]               r_s1Blk;
    logic                     r_s1Last;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_s1Valid <= 1'b0;
            r_s1Coef  <= '0;
            r_s1S     <= '0;
            r_s1Q     <= '0;
            r_s1Index <= 6'd0;
            r_s1Blk   <= 3'd0;
            r_s1Last  <= 1'b0;
        end else if (w_s0Adv) begin
            r_s1Valid <= r_s0Valid;
            if (r_s0Valid) begin
                r_s1Coef  <= r_s0Coef;
                r_s1S     <= w_effS;
                r_s1Q     <= w_effQ;
                r_s1Index <= r_s0Index;
                r_s1Blk   <= r_s0Blk;
                r_s1Last  <= r_s0Last;
            end
        end
    end

    // Product width has two guard bits over the operand widths, so no overflow.
    logic signed [c_PROD_W-1:0] w_coefExt, w_sExt, w_qExt, w_prod, w_round;
    logic [OUT_W-1:0]           w_outCoef;

    assign w_coefExt = c_PROD_W'(r_s1Coef);
    assign w_sExt    = signed'(c_PROD_W'(r_s1S));
    assign w_qExt    = signed'(c_PROD_W'(r_s1Q));
    assign w_prod    = w_coefExt * w_sExt * w_qExt;
    assign w_round   = (w_prod + c_RND) >>> 3;

    always_comb begin
        w_outCoef = w_round[OUT_W-1:0];
        if (w_round > c_SAT_MAX) begin
            w_outCoef = c_SAT_MAX[OUT_W-1:0];
        end else if (w_round < c_SAT_MIN) begin
            w_outCoef = c_SAT_MIN[OUT_W-1:0];
        end
    end

    // ---------------- output register ----------------
    logic [OUT_W-1:0] r_outCoef;
    logic [5:0]       r_outIndex;
    logic [2:0]       r_outBlk;
    logic             r_outLast;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_outValid <= 1'b0;
            r_outCoef  <= '0;
            r_outIndex <= 6'd0;
            r_outBlk   <= 3'd0;
            r_outLast  <= 1'b0;
        end else if (w_s1Adv) begin
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outCoef  <= w_outCoef;
                r_outIndex <= r_s1Index;
                r_outBlk   <= r_s1Blk;
                r_outLast  <= r_s1Last;
            end
        end
    end

    assign o_valid    = r_outValid;
    assign o_coef     = r_outCoef;
    assign o_index    = r_outIndex;
    assign o_blockNum = r_outBlk;
    assign o_last     = r_outLast;

`ifdef DEQUANT_SAT_CNT_EN
    // ---------------- clamp counter ----------------
    logic        w_sat, r_outSat;
    logic [15:0] r_satCount;

    assign w_sat = (w_round > c_SAT_MAX) || (w_round < c_SAT_MIN);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_outSat   <= 1'b0;
            r_satCount <= 16'd0;
        end else begin
            if (w_s1Adv && r_s1Valid) begin
                r_outSat <= w_sat;
            end
            if (i_satClr) begin
                r_satCount <= 16'd0;
            end else if (r_outValid && i_ready && r_outSat && (r_satCount != 16'hFFFF)) begin
                r_satCount <= r_satCount + 16'd1;
            end
        end
    end

    assign o_satCount = r_satCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coef_dequant_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_coef_dequant_pipe                                             |
// | Purpose  : Directed self-checking bench for coef_dequant_pipe.              |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_coef_dequant_pipe;

    localparam int COEF_W     = 10;
    localparam int SCALE_W    = 6;
    localparam int QUANT_W    = 7;
    localparam int OUT_W      = 12;
    localparam int NUM_TABLES = 2;
    localparam int TBL_W      = 1;

    logic                 i_clk = 1'b0;
    logic                 i_nrst;
    logic                 i_valid;
    logic                 o_ready;
    logic [COEF_W-1:0]    i_coef;
    logic [SCALE_W-1:0]   i_scale;
    logic                 i_isDC;
    logic [5:0]           i_index;
    logic [5:0]           i_linearIndex;
    logic [TBL_W-1:0]     i_tblSel;
    logic                 i_fullBlock;
    logic [2:0]           i_blockNum;
    logic                 i_last;
    logic                 i_qWrt;
    logic [TBL_W-1:0]     i_qTbl;
    logic [3:0]           i_qAdr;
    logic [4*QUANT_W-1:0] i_qValue;
    logic                 o_valid;
    logic                 i_ready;
    logic [5:0]           o_index;
    logic [2:0]           o_blockNum;
    logic                 o_last;
    logic [OUT_W-1:0]     o_coef;
`ifdef DEQUANT_SAT_CNT_EN
    logic [15:0]          o_satCount;
    logic                 i_satClr;
`endif

    int nTests = 0;
    int nFail  = 0;

    coef_dequant_pipe #(
        .COEF_W(COEF_W), .SCALE_W(SCALE_W), .QUANT_W(QUANT_W),
        .OUT_W(OUT_W), .NUM_TABLES(NUM_TABLES)
    ) dut (
        .i_clk(i_clk), .i_nrst(i_nrst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_coef(i_coef), .i_scale(i_scale), .i_isDC(i_isDC),
        .i_index(i_index), .i_linearIndex(i_linearIndex), .i_tblSel(i_tblSel),
        .i_fullBlock(i_fullBlock), .i_blockNum(i_blockNum), .i_last(i_last),
        .i_qWrt(i_qWrt), .i_qTbl(i_qTbl), .i_qAdr(i_qAdr), .i_qValue(i_qValue),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_index(o_index), .o_blockNum(o_blockNum), .o_last(o_last),
`ifdef DEQUANT_SAT_CNT_EN
        .o_satCount(o_satCount), .i_satClr(i_satClr),
`endif
        .o_coef(o_coef)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [4*QUANT_W-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {7'(e3), 7'(e2), 7'(e1), 7'(e0)};
    endfunction

    task automatic write_word(input int tbl, input int adr, input logic [4*QUANT_W-1:0] val);
        i_qWrt   = 1'b1;
        i_qTbl   = TBL_W'(tbl);
        i_qAdr   = 4'(adr);
        i_qValue = val;
        tick();
        i_qWrt   = 1'b0;
    endtask

    task automatic set_item(input int coef, input int scale, input bit dc, input int lin, input int tbl,
                            input bit full, input int idx, input int blk, input bit last);
        i_coef        = COEF_W'(coef);
        i_scale       = SCALE_W'(scale);
        i_isDC        = dc;
        i_linearIndex = 6'(lin);
        i_tblSel      = TBL_W'(tbl);
        i_fullBlock   = full;
        i_index       = 6'(idx);
        i_blockNum    = 3'(blk);
        i_last        = last;
    endtask

    // Holds i_valid until the item is taken; returns just after the accept edge.
    task automatic send_one(output bit ok);
        ok = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (o_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        i_valid = 1'b0;
    endtask

    // With i_ready high, returns the next output and consumes it.
    task automatic wait_out(output logic [OUT_W-1:0] c, output logic [5:0] idx, output bit ok);
        ok = 1'b0;
        c = '0;
        idx = '0;
        for (int k = 0; k < 20; k++) begin
            if (o_valid) begin
                c = o_coef;
                idx = o_index;
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        i_nrst = 1'b0;
        tick();
        tick();
        nTests++; if (o_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        nTests++; if (o_coef !== '0) begin nFail++; $display("FAIL reset_coef got=%h exp=0", o_coef); end
        nTests++; if ({o_index, o_blockNum, o_last} !== 10'd0) begin nFail++;
            $display("FAIL reset_sideband got=%h/%h/%b exp=0", o_index, o_blockNum, o_last); end
        i_nrst = 1'b1;
        #1;
        nTests++; if (o_ready !== 1'b1) begin nFail++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        tick();
    endtask

    task automatic load_tables();
        write_word(0, 0, pack4(2, 127, 3, 3));
        write_word(0, 1, pack4(1, 2, 3, 4));
        write_word(1, 0, pack4(5, 6, 7, 8));
        write_word(1, 2, pack4(10, 10, 10, 10));
    endtask

    task automatic test_dc_latency();
        bit ok;
        logic [OUT_W-1:0] expC;
        expC = OUT_W'(-6);
        i_ready = 1'b1;
        set_item(-3, 5, 1'b1, 0, 0, 1'b0, 17, 5, 1'b1);
        send_one(ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL dc_accept got=timeout exp=accept"); end
        nTests++; if (o_valid !== 1'b0) begin nFail++; $display("FAIL dc_lat1 got=%b exp=0", o_valid); end
        tick();
        nTests++; if (o_valid !== 1'b0) begin nFail++; $display("FAIL dc_lat2 got=%b exp=0", o_valid); end
        tick();
        nTests++; if (o_valid !== 1'b1) begin nFail++; $display("FAIL dc_lat3 got=%b exp=1", o_valid); end
        nTests++; if (o_coef !== expC) begin nFail++;
            $display("FAIL dc_coef got=%0d exp=%0d", $signed(o_coef), $signed(expC)); end
        nTests++; if ({o_index, o_blockNum, o_last} !== {6'd17, 3'd5, 1'b1}) begin nFail++;
            $display("FAIL dc_sideband got=%0d/%0d/%b exp=17/5/1", o_index, o_blockNum, o_last); end
        tick();
        nTests++; if (o_valid !== 1'b0) begin nFail++; $display("FAIL dc_single got=%b exp=0", o_valid); end
    endtask

    task automatic test_saturation();
        bit ok, ok2;
        logic [OUT_W-1:0] c;
        logic [5:0] idx;
        i_ready = 1'b1;
        set_item(511, 63, 1'b0, 1, 0, 1'b0, 1, 0, 1'b0);
        send_one(ok);
        wait_out(c, idx, ok2);
        nTests++; if (!(ok && ok2) || c !== 12'd2047) begin nFail++;
            $display("FAIL sat_pos got=%0d ok=%b exp=2047", $signed(c), ok && ok2); end
`ifdef DEQUANT_SAT_CNT_EN
        nTests++; if (o_satCount !== 16'd1) begin nFail++; $display("FAIL satcnt_1 got=%0d exp=1", o_satCount); end
`endif
        set_item(-512, 63, 1'b0, 1, 0, 1'b0, 2, 0, 1'b0);
        send_one(ok);
        wait_out(c, idx, ok2);
        nTests++; if (!(ok && ok2) || c !== 12'h800) begin nFail++;
            $display("FAIL sat_neg got=%0d ok=%b exp=-2048", $signed(c), ok && ok2); end
`ifdef DEQUANT_SAT_CNT_EN
        nTests++; if (o_satCount !== 16'd2) begin nFail++; $display("FAIL satcnt_2 got=%0d exp=2", o_satCount); end
        i_satClr = 1'b1;
        tick();
        i_satClr = 1'b0;
        nTests++; if (o_satCount !== 16'd0) begin nFail++; $display("FAIL satcnt_clr got=%0d exp=0", o_satCount); end
`endif
        set_item(100, 0, 1'b0, 1, 0, 1'b0, 3, 0, 1'b0);
        send_one(ok);
        wait_out(c, idx, ok2);
        nTests++; if (!(ok && ok2) || c !== 12'd0) begin nFail++;
            $display("FAIL ac_scale0 got=%0d ok=%b exp=0", $signed(c), ok && ok2); end
    endtask

    task automatic test_full_block();
        bit ok, ok2;
        logic [OUT_W-1:0] c;
        logic [5:0] idx;
        i_ready = 1'b1;
        set_item(-512, 3, 1'b0, 9, 1, 1'b1, 4, 0, 1'b0);
        send_one(ok);
        wait_out(c, idx, ok2);
        nTests++; if (!(ok && ok2) || c !== OUT_W'(-1024)) begin nFail++;
            $display("FAIL full_neg got=%0d ok=%b exp=-1024", $signed(c), ok && ok2); end
        set_item(1, 3, 1'b0, 9, 1, 1'b1, 5, 0, 1'b0);
        send_one(ok);
        wait_out(c, idx, ok2);
        nTests++; if (!(ok && ok2) || c !== 12'd2) begin nFail++;
            $display("FAIL full_one got=%0d ok=%b exp=2", $signed(c), ok && ok2); end
    endtask

    task automatic test_back_to_back_stall();
        int  sent, got, cyc, lin, tbl;
        bit  stallSeen, acceptNow;
        sent = 0; got = 0; cyc = 0; stallSeen = 1'b0;
        while (got < 8 && cyc < 100) begin
            i_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 8) begin
                lin = (sent < 4) ? 4 + sent : sent - 4;
                tbl = (sent < 4) ? 0 : 1;
                set_item(1, 8, 1'b0, lin, tbl, 1'b0, sent, sent, sent == 7);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (o_valid && i_ready) begin
                nTests++;
                if (o_coef !== OUT_W'(got + 1) || o_index !== 6'(got)) begin nFail++;
                    $display("FAIL stream_item%0d got=%0d idx=%0d exp=%0d idx=%0d",
                             got, $signed(o_coef), o_index, got + 1, got); end
                got++;
            end
            if (!i_ready && !o_ready) stallSeen = 1'b1;
            acceptNow = i_valid && o_ready;
            @(posedge i_clk);
            #1;
            if (acceptNow) sent++;
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        nTests++; if (got != 8 || sent != 8) begin nFail++;
            $display("FAIL stream_count got=%0d sent=%0d exp=8/8", got, sent); end
        nTests++; if (!stallSeen) begin nFail++; $display("FAIL stream_backpressure got=ready_high exp=ready_low"); end
        for (int k = 0; k < 5; k++) begin
            tick();
            nTests++; if (o_valid !== 1'b0) begin nFail++; $display("FAIL stream_extra got=%b exp=0", o_valid); end
        end
    endtask

    task automatic test_write_collision();
        bit ok1, ok2;
        logic [OUT_W-1:0] c;
        logic [5:0] idx;
        i_ready = 1'b1;
        set_item(1, 8, 1'b0, 8, 1, 1'b0, 40, 1, 1'b0);
        i_valid  = 1'b1;
        i_qWrt   = 1'b1;
        i_qTbl   = 1'b1;
        i_qAdr   = 4'd2;
        i_qValue = pack4(20, 20, 20, 20);
        #1;
        nTests++; if (o_ready !== 1'b1) begin nFail++; $display("FAIL wr_ready got=%b exp=1", o_ready); end
        tick();
        i_qWrt = 1'b0;
        set_item(1, 8, 1'b0, 8, 1, 1'b0, 41, 1, 1'b0);
        tick();
        i_valid = 1'b0;
        wait_out(c, idx, ok1);
        nTests++; if (!ok1 || c !== 12'd10 || idx !== 6'd40) begin nFail++;
            $display("FAIL wr_old got=%0d idx=%0d exp=10 idx=40", $signed(c), idx); end
        wait_out(c, idx, ok2);
        nTests++; if (!ok2 || c !== 12'd20 || idx !== 6'd41) begin nFail++;
            $display("FAIL wr_new got=%0d idx=%0d exp=20 idx=41", $signed(c), idx); end
    endtask

    task automatic test_async_reset();
        bit stale, ok, ok2;
        logic [OUT_W-1:0] c;
        logic [5:0] idx;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_item(5 + k, 1, 1'b0, 0, 0, 1'b1, 50 + k, 2, 1'b0);
            i_valid = 1'b1;
            tick();
        end
        i_valid = 1'b0;
        nTests++; if (o_valid !== 1'b1) begin nFail++; $display("FAIL rst_inflight got=%b exp=1", o_valid); end
        i_nrst = 1'b0;
        #1;
        nTests++; if (o_valid !== 1'b0) begin nFail++; $display("FAIL rst_async_valid got=%b exp=0", o_valid); end
        tick();
        tick();
        i_nrst = 1'b1;
        #1;
        nTests++; if (o_ready !== 1'b1) begin nFail++; $display("FAIL rst_release_ready got=%b exp=1", o_ready); end
        stale = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (o_valid) stale = 1'b1;
        end
        nTests++; if (stale) begin nFail++; $display("FAIL rst_stale got=valid exp=none"); end
        set_item(-3, 1, 1'b1, 0, 0, 1'b0, 0, 0, 1'b0);
        send_one(ok);
        wait_out(c, idx, ok2);
        nTests++; if (!(ok && ok2) || c !== OUT_W'(-6)) begin nFail++;
            $display("FAIL rst_tables_kept got=%0d ok=%b exp=-6", $signed(c), ok && ok2); end
    endtask

    initial begin
        i_valid = 1'b0; i_ready = 1'b1; i_qWrt = 1'b0; i_qTbl = '0; i_qAdr = '0; i_qValue = '0;
        set_item(0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
`ifdef DEQUANT_SAT_CNT_EN
        i_satClr = 1'b0;
`endif
        test_reset();
        load_tables();
        test_dc_latency();
        test_saturation();
        test_full_block();
        test_back_to_back_stall();
        test_write_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
